uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- Standalone UART receiver: 8N1, LSB first, idle-high line.
- Receive side of the keypad/LED UART link. It is the counterpart of the transmitter that serialises keypad ASCII codes.
- Delivers each received byte through a valid/ready holding register.
- Reports framing errors and overruns. Downstream logic uses it to drive the LEDs or feed the host-side model.

Parameters:
- CLKS_PER_BIT, 2813: clock cycles per bit. 27 MHz / 9600 baud, rounded.
- HALF_BIT, CLKS_PER_BIT/2 (1406): offset from the start-bit edge to the mid-bit sample point.
- SYNC_STAGES, 2: number of flip-flops in the rx input synchroniser.

Ports:
- clk  in  1  system clock, 27 MHz.
- rst  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial line, idle high.
- rx_data  out  8  last accepted byte. Stable while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts the byte when rx_valid&&rx_ready on a clk edge.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  out  1  sticky. A complete frame arrived while the holding register was still full.
- overrun_clr  in  1  clears overrun.
- busy  out  1  high in every state except IDLE and WAIT_IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Synchroniser flops go to 1; rx_data=0x00; rx_valid=0; frame_err=0; overrun=0; busy=0.
  - State goes to WAIT_IDLE, bit counter and cycle counter go to 0.
  - Reset mid-frame abandons the frame, with no error reported.
- rx is sampled only through the SYNC_STAGES synchroniser. rx_s is the synchronised bit; rx_prev is rx_s delayed by one cycle.
- WAIT_IDLE: requires rx_s=1 for CLKS_PER_BIT consecutive cycles, then goes to IDLE. Any 0 restarts the count. This state handles resync after reset, a framing error, or a break.
- IDLE: when rx_prev=1 and rx_s=0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt=HALF_BIT-1, sample rx_s:
  - rx_s=0: go to DATA with cnt=0 and bit_idx=0.
  - rx_s=1: glitch. Return to IDLE, with no outputs changed.
- DATA: at cnt=CLKS_PER_BIT-1, shift rx_s into the shift register MSB (shift right, so the first bit received ends up in bit 0), set cnt=0, increment bit_idx. After the sample with bit_idx=7, go to STOP.
- STOP: at cnt=CLKS_PER_BIT-1, sample rx_s.
  - 1, register empty or being consumed this cycle: load rx_data from the shift register, set rx_valid=1 on the next edge, go to IDLE (back-to-back frames allowed).
  - 1, register full and not consumed this cycle: new byte dropped, rx_data keeps the old value, overrun=1, go to IDLE.
  - 0: frame_err=1 for exactly one cycle, byte discarded, go to WAIT_IDLE.
- Handshake: rx_valid clears on the edge where rx_valid&&rx_ready, unless a new byte loads on that same edge. A simultaneous consume and load keeps rx_valid=1 with the new data, and does not set overrun.
- overrun_clr: clears overrun. If overrun_clr is high on the same edge that a new overrun occurs, the set wins.
- Latency: rx_valid rises 2+HALF_BIT+9*CLKS_PER_BIT cycles after the rx falling edge at the pin (26725 at defaults). The bench tolerance is ±2 cycles.
- Widths:
  - cnt is $clog2(CLKS_PER_BIT) bits and never wraps; it is reset explicitly at each bit boundary.
  - bit_idx is 3 bits.

Decomposition:
- Package uart_pkg holds:
  - state enum uart_rx_state_t {WAIT_IDLE, IDLE, START, DATA, STOP};
  - CLK_FREQ_HZ=27_000_000, BAUD=9600, CLKS_PER_BIT_DEF=2813, DATA_BITS=8.
  - These constants are shared with the transmitter.
- One sub-module, sync_2ff (parameterised depth and reset value 1). It is reused for the keypad inputs.

Test Plan:
- After reset, line held high for 1 bit time, then send 0x41 ('A') at CLKS_PER_BIT -> rx_data=0x41, rx_valid=1 within 26725±2 cycles, frame_err=0, overrun=0.
- rx low for 500 cycles, then high -> no rx_valid, no frame_err, state back to IDLE. A following 0x35 frame is received correctly.
- Frame 0x7E with stop bit forced 0 -> single-cycle frame_err, rx_valid stays 0. Frames sent while the line has not yet been high for one bit time are ignored. The next frame, 0x23, after one bit time of line high is received.
- rx_ready held 0, send 0x31 then 0x32 -> rx_data=0x31, overrun=1. Pulse rx_ready for one cycle -> rx_valid=0. Pulse overrun_clr -> overrun=0.
- rx_ready tied 1, back-to-back frames 0x00 and 0xFF with no idle gap -> two rx_valid pulses carrying 0x00 then 0xFF, no errors.
- Assert rst low mid-DATA of frame 0x55 -> all outputs 0 on the next edge, busy=0. After release, a mid-frame line does not produce a byte; the next full 0x2A frame is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants and types shared by the keypad/LED UART transmitter and receiver.
// 8N1 framing at 9600 baud from a 27 MHz core clock.
package uart_pkg;

  localparam int CLK_FREQ_HZ      = 27_000_000;
  localparam int BAUD             = 9600;
  localparam int CLKS_PER_BIT_DEF = 2813;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input; 1 cycle per stage latency.
// No backpressure; all stages load RST_VAL on synchronous active-low reset.
module sync_2ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver feeding a one-entry valid/ready holding register; byte valid 2+HALF_BIT+9*CLKS_PER_BIT cycles after the start edge.
// A byte finishing while the register is full and not being consumed is dropped and flags sticky overrun.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  uart_rx_state_t       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_prev_q, rx_prev_d;

  logic rx_s;
  logic consume;
  logic load;
  logic drop;

  sync_2ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    frame_err_d = 1'b0;
    rx_prev_d   = rx_s;
    load        = 1'b0;
    drop        = 1'b0;
    consume     = rx_valid_q && rx_ready;

    case (state_q)
      // Line must stay high a full bit time before a falling edge counts as a start bit.
      WAIT_IDLE: begin
        if (!rx_s) begin
          cnt_d = '0;
        end else if (cnt_q == BIT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (!rx_valid_q || consume) begin
              load = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end else begin
            state_d     = WAIT_IDLE;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = WAIT_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (load) begin
      rx_data_d = shreg_q;
    end
    // A load on the consume edge keeps the register full with the new byte.
    rx_valid_d = load || (rx_valid_q && !consume);
    overrun_d  = drop || (overrun_q && !overrun_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_prev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rx_prev_q   <= rx_prev_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE) && (state_q != WAIT_IDLE);

endmodule
